// File: rtl/branch_target_lut.sv
// Programmable branch-target table with self-clearing init sequencer; optional parity via LUT_PARITY_EN.
// Latency: lookup response registered one cycle after an accepted request.
// Backpressure: req_ready low while the table is being cleared; writes ignored until then.
module branch_target_lut #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int TARGET_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [TARGET_W-1:0] wr_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_idx,
  input  logic [1:0]          req_kind,
  input  logic                req_zero,
  input  logic [TARGET_W-1:0] req_pc,
  output logic                rsp_valid,
  output logic                rsp_take,
  output logic [TARGET_W-1:0] rsp_target
`ifdef LUT_PARITY_EN
  ,
  output logic                err
`endif
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BZ   = 2'd1;
  localparam logic [1:0] KIND_BNZ  = 2'd2;
  localparam logic [1:0] KIND_JMP  = 2'd3;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [TARGET_W-1:0] mem_dat [DEPTH];
  logic                accept, bypass, take;
  logic [TARGET_W-1:0] entry, pc_next, target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) cnt <= cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt == {ADDR_W{1'b1}}) state_nxt = ST_READY;
      end
      ST_READY: begin
        init_done = 1'b1;
        req_ready = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Data bits carry no reset; the init sequencer is the only clear path.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) mem_dat[cnt] <= '0;
      else if (wr_en)       mem_dat[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    accept  = req_valid && req_ready;
    bypass  = wr_en && (wr_addr == req_idx);
    entry   = bypass ? wr_data : mem_dat[req_idx];
    pc_next = req_pc + TARGET_W'(1);
    take    = 1'b0;
    case (req_kind)
      KIND_NONE: take = 1'b0;
      KIND_BZ:   take = req_zero;
      KIND_BNZ:  take = !req_zero;
      KIND_JMP:  take = 1'b1;
      default:   take = 1'b0;
    endcase
    target = take ? entry : pc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_take   <= 1'b0;
      rsp_target <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_take   <= take;
        rsp_target <= target;
      end
    end
  end

`ifdef LUT_PARITY_EN
  logic mem_par [DEPTH];
  logic par_bad;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) mem_par[cnt] <= 1'b0;
      else if (wr_en)       mem_par[wr_addr] <= ^wr_data;
    end
  end

  // Only stored entries are checked; a bypassed write never touched the array.
  assign par_bad = accept && take && !bypass && ((^mem_dat[req_idx]) != mem_par[req_idx]);

  always_ff @(posedge clk) begin
    if (!rst_n)       err <= 1'b0;
    else if (par_bad) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_branch_target_lut.sv
// Directed bench for branch_target_lut; parity checks compiled in with LUT_PARITY_EN.
module tb_branch_target_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_idx;
  logic [1:0] req_kind;
  logic       req_zero;
  logic [7:0] req_pc;
  logic       rsp_valid;
  logic       rsp_take;
  logic [7:0] rsp_target;
`ifdef LUT_PARITY_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_target_lut dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .req_kind   (req_kind),
    .req_zero   (req_zero),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_take   (rsp_take),
    .rsp_target (rsp_target)
`ifdef LUT_PARITY_EN
    ,
    .err        (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from reset release until init_done; a hung init reports 40.
  task automatic wait_init(output int n, output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (n < 40) begin
      wr_en = (n == 14);
      step();
      n++;
      if (rsp_valid) saw_rsp = 1'b1;
      if (init_done) break;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [1:0] kind, input logic [3:0] idx,
                        input logic zero, input logic [7:0] pc,
                        input logic exp_take, input logic [7:0] exp_tgt);
    req_valid = 1'b1;
    req_kind  = kind;
    req_idx   = idx;
    req_zero  = zero;
    req_pc    = pc;
    step();
    req_valid = 1'b0;
    check({tag, ".vld"},  rsp_valid,  1);
    check({tag, ".take"}, rsp_take,   exp_take);
    check({tag, ".tgt"},  rsp_target, exp_tgt);
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  int   n;
  logic saw;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_idx = '0; req_kind = '0; req_zero = 1'b0; req_pc = '0;
    step(); step();
    check("rst.init_done", init_done, 0);
    check("rst.req_ready", req_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_take",  rsp_take,  0);
    check("rst.rsp_tgt",   rsp_target, 0);
`ifdef LUT_PARITY_EN
    check("rst.err", err, 0);
`endif

    // Requests and a write to entry 3 during INIT must be ignored.
    rst_n = 1'b1;
    req_valid = 1'b1; req_kind = 2'd3; req_idx = 4'd3;
    wr_addr = 4'd3; wr_data = 8'h77;
    wait_init(n, saw);
    req_valid = 1'b0;
    check("init.cycles",   n, 16);
    check("init.no_rsp",   saw, 0);
    check("init.ready",    req_ready, 1);

    do_req("jmp3_clear", 2'd3, 4'd3, 1'b0, 8'h00, 1, 8'h00);
    do_req("jmp9_clear", 2'd3, 4'd9, 1'b0, 8'h00, 1, 8'h00);

    do_wr(4'd5, 8'hA3);
    do_req("bz_taken",  2'd1, 4'd5, 1'b1, 8'h10, 1, 8'hA3);
    do_req("bz_not",    2'd1, 4'd5, 1'b0, 8'h10, 0, 8'h11);
    step();
    check("idle.vld",  rsp_valid,  0);
    check("idle.take", rsp_take,   0);
    check("idle.tgt",  rsp_target, 8'h11);

    do_req("bnz_taken", 2'd2, 4'd5, 1'b0, 8'h20, 1, 8'hA3);
    do_req("bnz_not",   2'd2, 4'd5, 1'b1, 8'h20, 0, 8'h21);
    do_req("none_wrap", 2'd0, 4'd5, 1'b1, 8'hFF, 0, 8'h00);
    do_req("none_z",    2'd0, 4'd5, 1'b1, 8'h10, 0, 8'h11);
    do_req("b2b_a",     2'd3, 4'd5, 1'b0, 8'h30, 1, 8'hA3);
    do_req("b2b_b",     2'd1, 4'd5, 1'b0, 8'h30, 0, 8'h31);

    // Write-first bypass on the same index.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h42;
    do_req("bypass",    2'd3, 4'd3, 1'b0, 8'h00, 1, 8'h42);
    wr_en = 1'b0;
    do_req("after_wr",  2'd3, 4'd3, 1'b0, 8'h00, 1, 8'h42);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h55;
    do_req("bypass_nt", 2'd1, 4'd3, 1'b0, 8'h40, 0, 8'h41);
    wr_en = 1'b0;
    do_req("after_wr2", 2'd3, 4'd3, 1'b0, 8'h00, 1, 8'h55);
    do_wr(4'd7, 8'h99);
    do_req("jmp7",      2'd3, 4'd7, 1'b0, 8'h00, 1, 8'h99);
`ifdef LUT_PARITY_EN
    check("par.clean_err", err, 0);
`endif

    // Reset from READY, then again at INIT cycle 7.
    rst_n = 1'b0;
    step();
    check("rst2.ready", req_ready, 0);
    rst_n = 1'b1;
    repeat (7) step();
    check("mid.init_done", init_done, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_init(n, saw);
    check("reinit.cycles", n, 16);
    do_req("re_jmp3", 2'd3, 4'd3, 1'b0, 8'h00, 1, 8'h00);
    do_req("re_jmp5", 2'd3, 4'd5, 1'b0, 8'h00, 1, 8'h00);
    do_req("re_jmp7", 2'd3, 4'd7, 1'b0, 8'h00, 1, 8'h00);

`ifdef LUT_PARITY_EN
    do_wr(4'd2, 8'h01);
    do_req("par_ok", 2'd3, 4'd2, 1'b0, 8'h00, 1, 8'h01);
    check("par.ok_err", err, 0);
    dut.mem_dat[2] = 8'h00;
    do_req("par_bad", 2'd3, 4'd2, 1'b0, 8'h00, 1, 8'h00);
    check("par.err_set", err, 1);
    step(); step();
    check("par.err_sticky", err, 1);
    rst_n = 1'b0;
    step();
    check("par.err_rst", err, 0);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
